// File: rtl/ecc_pkg.sv
// Shared types for the ECC result path: CTRL mode encoding, error codes
// and the per-result status record that travels with each data word.
package ecc_pkg;

    typedef enum logic [1:0] {
        ENC_ONLY = 2'b00,
        DEC_ONLY = 2'b01,
        FULL_CH  = 2'b10
    } ecc_mode_t;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_SINGLE = 2'b01;
    localparam logic [1:0] ERR_DOUBLE = 2'b10;

    // Result record. The data word is carried next to it by the collector
    // because its width is a module parameter.
    typedef struct packed {
        logic [1:0] errors;
        ecc_mode_t  mode;
    } ecc_result_t;

    // Fold the raw CTRL/num_of_errors pair into a stored result:
    // mode 11 behaves as encode-only, encode-only never reports errors,
    // and the reserved error code 11 is reported as uncorrectable.
    function automatic ecc_result_t ecc_normalise(input logic [1:0] mode_raw,
                                                  input logic [1:0] err_raw);
        ecc_result_t r;
        r.mode = (mode_raw == 2'b11) ? ENC_ONLY : ecc_mode_t'(mode_raw);
        if (r.mode == ENC_ONLY)
            r.errors = ERR_NONE;
        else if (err_raw == 2'b11)
            r.errors = ERR_DOUBLE;
        else
            r.errors = err_raw;
        return r;
    endfunction

endpackage

// File: rtl/ecc_sync_fifo.sv
// Small register-based synchronous FIFO with first-word fall-through head.
module ecc_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_MAX = DEPTH;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_pop;
    logic          w_push;

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // allowed when it coincides with a pop.
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);

    assign empty = (r_count == '0);
    assign full  = (r_count == CNT_MAX);
    assign count = r_count;
    assign rdata = r_mem[r_rd_ptr];

    // Storage is cleared on reset so the head reads zero while empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); count tracks push-pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ecc_result_collector.sv
// Captures ECC results on the operation_done rising edge, queues them for a
// valid/ready consumer and keeps saturating error statistics.
module ecc_result_collector
    import ecc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          operation_done,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic [1:0]                    num_of_errors,
    input  logic [1:0]                    ctrl_mode,
    input  logic                          clr_stats,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [1:0]                    out_errors,
    output logic [1:0]                    out_mode,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic [CNT_WIDTH-1:0]          cnt_total,
    output logic [CNT_WIDTH-1:0]          cnt_single,
    output logic [CNT_WIDTH-1:0]          cnt_double,
    output logic [CNT_WIDTH-1:0]          cnt_dropped
);

    localparam int EW = DATA_WIDTH + $bits(ecc_result_t);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    logic                 r_done_d;
    logic                 w_capture;
    logic                 w_pop;
    logic                 w_accept;
    logic                 w_drop;
    logic                 w_full;
    logic                 w_empty;
    ecc_result_t          w_norm;
    ecc_result_t          w_head;
    logic [EW-1:0]        w_rdata;
    logic [CNT_WIDTH-1:0] r_cnt_total;
    logic [CNT_WIDTH-1:0] r_cnt_single;
    logic [CNT_WIDTH-1:0] r_cnt_double;
    logic [CNT_WIDTH-1:0] r_cnt_dropped;
    logic                 r_overflow;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + CNT_ONE;
    endfunction

    assign w_capture = operation_done & ~r_done_d;
    assign w_norm    = ecc_normalise(ctrl_mode, num_of_errors);
    assign w_pop     = ~w_empty & out_ready;
    assign w_accept  = w_capture & (~w_full | w_pop);
    assign w_drop    = w_capture & w_full & ~w_pop;

    ecc_sync_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_accept),
        .pop   (w_pop),
        .wdata ({data_in, w_norm}),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty),
        .count (fifo_count)
    );

    assign {out_data, w_head} = w_rdata;
    assign out_valid   = ~w_empty;
    assign out_errors  = w_head.errors;
    assign out_mode    = w_head.mode;
    assign overflow    = r_overflow;
    assign cnt_total   = r_cnt_total;
    assign cnt_single  = r_cnt_single;
    assign cnt_double  = r_cnt_double;
    assign cnt_dropped = r_cnt_dropped;

    // Delayed strobe for rising-edge detection: a held level captures once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_done_d <= 1'b0;
        else      r_done_d <= operation_done;
    end

    // Statistics: saturating counters and sticky overflow; clear beats increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt_total   <= '0;
            r_cnt_single  <= '0;
            r_cnt_double  <= '0;
            r_cnt_dropped <= '0;
            r_overflow    <= 1'b0;
        end else if (clr_stats) begin
            r_cnt_total   <= '0;
            r_cnt_single  <= '0;
            r_cnt_double  <= '0;
            r_cnt_dropped <= '0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_accept)                             r_cnt_total  <= sat_inc(r_cnt_total);
            if (w_accept && w_norm.errors == ERR_SINGLE) r_cnt_single <= sat_inc(r_cnt_single);
            if (w_accept && w_norm.errors == ERR_DOUBLE) r_cnt_double <= sat_inc(r_cnt_double);
            if (w_drop) begin
                r_cnt_dropped <= sat_inc(r_cnt_dropped);
                r_overflow    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ecc_result_collector.sv
// Directed bench for ecc_result_collector: a default instance plus a
// CNT_WIDTH=2 instance sharing the same stimulus for saturation checks.
module tb_ecc_result_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        operation_done = 1'b0;
    logic [31:0] data_in = '0;
    logic [1:0]  num_of_errors = '0;
    logic [1:0]  ctrl_mode = '0;
    logic        clr_stats = 1'b0;
    logic        out_ready = 1'b0;

    logic        out_valid, out_valid2;
    logic [31:0] out_data, out_data2;
    logic [1:0]  out_errors, out_errors2, out_mode, out_mode2;
    logic [2:0]  fifo_count, fifo_count2;
    logic        overflow, overflow2;
    logic [15:0] cnt_total, cnt_single, cnt_double, cnt_dropped;
    logic [1:0]  cnt_total2, cnt_single2, cnt_double2, cnt_dropped2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ecc_result_collector #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .operation_done(operation_done), .data_in(data_in),
        .num_of_errors(num_of_errors), .ctrl_mode(ctrl_mode), .clr_stats(clr_stats),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_errors(out_errors), .out_mode(out_mode), .fifo_count(fifo_count),
        .overflow(overflow), .cnt_total(cnt_total), .cnt_single(cnt_single),
        .cnt_double(cnt_double), .cnt_dropped(cnt_dropped)
    );

    ecc_result_collector #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .CNT_WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .operation_done(operation_done), .data_in(data_in),
        .num_of_errors(num_of_errors), .ctrl_mode(ctrl_mode), .clr_stats(clr_stats),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .out_errors(out_errors2), .out_mode(out_mode2), .fifo_count(fifo_count2),
        .overflow(overflow2), .cnt_total(cnt_total2), .cnt_single(cnt_single2),
        .cnt_double(cnt_double2), .cnt_dropped(cnt_dropped2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle completion strobe followed by one idle cycle.
    task automatic pulse(input logic [31:0] d, input logic [1:0] e, input logic [1:0] m);
        operation_done = 1'b1; data_in = d; num_of_errors = e; ctrl_mode = m;
        step();
        operation_done = 1'b0;
        step();
    endtask

    task automatic clear_stats();
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---- reset state
        step(); step();
        chk("rst_valid", out_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_total", cnt_total, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_data", out_data, 0);
        rst = 1'b1;
        step();

        // ---- 1: single DEC_ONLY pulse with one corrected error
        operation_done = 1'b1; data_in = 32'hA5A5_0001; num_of_errors = 2'b01; ctrl_mode = 2'b01;
        step();
        operation_done = 1'b0;
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 32'hA5A5_0001);
        chk("t1_err", out_errors, 2'b01);
        chk("t1_mode", out_mode, 2'b01);
        chk("t1_total", cnt_total, 1);
        chk("t1_single", cnt_single, 1);
        step();
        chk("t1_stable", out_data, 32'hA5A5_0001);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t1_drained", fifo_count, 0);

        // ---- 2: level held 5 cycles, encode only
        clear_stats();
        operation_done = 1'b1; data_in = 32'h2222_2222; num_of_errors = 2'b10; ctrl_mode = 2'b00;
        repeat (5) step();
        operation_done = 1'b0;
        chk("t2_count", fifo_count, 1);
        chk("t2_err", out_errors, 2'b00);
        chk("t2_total", cnt_total, 1);
        chk("t2_double", cnt_double, 0);
        step();
        out_ready = 1'b1; step(); out_ready = 1'b0;

        // ---- 2b: reserved error code and mode 11 normalisation
        clear_stats();
        pulse(32'h0000_0033, 2'b11, 2'b10);
        chk("t2b_err", out_errors, 2'b10);
        chk("t2b_mode", out_mode, 2'b10);
        chk("t2b_double", cnt_double, 1);
        pulse(32'h0000_0044, 2'b01, 2'b11);
        chk("t2b_total", cnt_total, 2);
        chk("t2b_single", cnt_single, 0);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("t2b_hdata", out_data, 32'h44);
        chk("t2b_herr", out_errors, 2'b00);
        chk("t2b_hmode", out_mode, 2'b00);
        out_ready = 1'b1; step(); out_ready = 1'b0;

        // ---- 3: overflow with 6 pulses into depth 4
        clear_stats();
        for (int i = 0; i < 6; i++) pulse(32'h30 + i, 2'b00, 2'b01);
        chk("t3_count", fifo_count, 4);
        chk("t3_ovf", overflow, 1);
        chk("t3_dropped", cnt_dropped, 2);
        chk("t3_total", cnt_total, 4);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t3_drain", out_data, 32'h30 + i);
            step();
        end
        out_ready = 1'b0;
        chk("t3_empty", out_valid, 0);

        // ---- 4: full FIFO with simultaneous capture and pop
        clear_stats();
        chk("t4_ovf_clr", overflow, 0);
        for (int i = 0; i < 4; i++) pulse(32'h40 + i, 2'b00, 2'b01);
        operation_done = 1'b1; data_in = 32'h4F; out_ready = 1'b1;
        step();
        operation_done = 1'b0; out_ready = 1'b0;
        chk("t4_count", fifo_count, 4);
        chk("t4_ovf", overflow, 0);
        chk("t4_dropped", cnt_dropped, 0);
        chk("t4_total", cnt_total, 5);
        out_ready = 1'b1;
        chk("t4_d0", out_data, 32'h41); step();
        chk("t4_d1", out_data, 32'h42); step();
        chk("t4_d2", out_data, 32'h43); step();
        chk("t4_d3", out_data, 32'h4F); step();
        chk("t4_empty", fifo_count, 0);

        // ---- 4b: capture into empty FIFO while consumer is ready
        operation_done = 1'b1; data_in = 32'h55;
        step();
        operation_done = 1'b0;
        chk("t4b_count", fifo_count, 1);
        chk("t4b_data", out_data, 32'h55);
        step();
        chk("t4b_popped", fifo_count, 0);
        out_ready = 1'b0;

        // ---- 5: saturation on the 2-bit instance, clear beats increment
        rst = 1'b0; step(); rst = 1'b1; step();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) pulse(32'h60 + i, 2'b01, 2'b01);
        chk("t5_sat_single", cnt_single2, 3);
        chk("t5_sat_total", cnt_total2, 3);
        chk("t5_wide_single", cnt_single, 5);
        operation_done = 1'b1; clr_stats = 1'b1; data_in = 32'h6F;
        step();
        operation_done = 1'b0; clr_stats = 1'b0;
        chk("t5_clr_total2", cnt_total2, 0);
        chk("t5_clr_single2", cnt_single2, 0);
        chk("t5_clr_total", cnt_total, 0);
        chk("t5_clr_fifo", fifo_count, 1);
        step();
        out_ready = 1'b0;

        // ---- 6: asynchronous reset with 3 entries queued
        for (int i = 0; i < 3; i++) pulse(32'h70 + i, 2'b10, 2'b10);
        chk("t6_pre_count", fifo_count, 3);
        chk("t6_pre_total", cnt_total, 3);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_count", fifo_count, 0);
        chk("t6_total", cnt_total, 0);
        chk("t6_double", cnt_double, 0);
        chk("t6_data", out_data, 0);
        step();
        rst = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
